// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_unit_pkg;

   typedef enum logic [1:0] {
      MD_OP_MULT  = 2'd0,
      MD_OP_MULTU = 2'd1,
      MD_OP_DIV   = 2'd2,
      MD_OP_DIVU  = 2'd3
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } md_state_e;

   function automatic logic op_is_div(input md_op_e op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input md_op_e op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 datapath: shift-add multiply / restoring divide on operand magnitudes.
module muldiv_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a_mag,
   input  logic [WIDTH-1:0] b_mag,
   output logic [WIDTH-1:0] rem,
   output logic [WIDTH-1:0] quo,
   output logic             last_c
);

   localparam int unsigned CW = $clog2(WIDTH);

   logic [WIDTH-1:0] dvs;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;
   logic             unused_diff_msb;

   // rem holds the running high half (multiply) or partial remainder (divide)
   always_comb begin
      sum     = {1'b0, rem} + (quo[0] ? {1'b0, dvs} : (WIDTH+1)'(0));
      shifted = {rem, quo[WIDTH-1]};
      diff    = {1'b0, shifted} - {2'b00, dvs};
   end

   // After a successful subtract the difference is below the divisor
   assign unused_diff_msb = diff[WIDTH];
   assign last_c          = (cnt == CW'(WIDTH-1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem <= '0;
         quo <= '0;
         dvs <= '0;
         cnt <= '0;
      end else if (load) begin
         rem <= '0;
         quo <= a_mag;
         dvs <= b_mag;
         cnt <= '0;
      end else if (step) begin
         cnt <= cnt + CW'(1);
         if (is_div) begin
            if (diff[WIDTH+1]) begin
               rem <= shifted[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], 1'b0};
            end else begin
               rem <= diff[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], 1'b1};
            end
         end else begin
            rem <= sum[WIDTH:1];
            quo <= {sum[0], quo[WIDTH-1:1]};
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// MIPS-style HI/LO multiply/divide unit: control FSM, sign fix-up and HI/LO registers.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_cpu,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   input  logic             hi_wr,
   input  logic             lo_wr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   md_state_e        state, state_nxt;
   md_op_e           op_in;
   logic             sgn_in, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             div_q, neg_q, neg_r, b_zero_q;
   logic             load_c, step_c, fin_c, last_c;
   logic [WIDTH-1:0] rem, quo;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] res_hi, res_lo;

   // Operand magnitudes; unsigned ops never negate
   always_comb begin
      op_in  = md_op_e'(op);
      sgn_in = op_is_signed(op_in);
      a_neg  = sgn_in & a[WIDTH-1];
      b_neg  = sgn_in & b[WIDTH-1];
      a_mag  = a_neg ? WIDTH'(-a) : a;
      b_mag  = b_neg ? WIDTH'(-b) : b;
   end

   always_ff @(posedge clk_cpu or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start && !cancel) state_nxt = ST_RUN;
         ST_RUN:  if (cancel)           state_nxt = ST_IDLE;
                  else if (last_c)      state_nxt = ST_FIN;
         ST_FIN:                        state_nxt = ST_IDLE;
         default:                       state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      load_c = 1'b0;
      step_c = 1'b0;
      fin_c  = 1'b0;
      case (state)
         ST_IDLE: load_c = start & ~cancel;
         ST_RUN:  step_c = 1'b1;
         ST_FIN:  fin_c  = ~cancel;
         default: ;
      endcase
   end

   // Operation attributes captured on the accepting edge
   always_ff @(posedge clk_cpu or posedge reset) begin
      if (reset) begin
         div_q    <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         b_zero_q <= 1'b0;
      end else if (load_c) begin
         div_q    <= op_is_div(op_in);
         neg_q    <= a_neg ^ b_neg;
         neg_r    <= a_neg;
         b_zero_q <= (b == '0);
      end
   end

   muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk_cpu),
      .rst    (reset),
      .load   (load_c),
      .step   (step_c),
      .is_div (div_q),
      .a_mag  (a_mag),
      .b_mag  (b_mag),
      .rem    (rem),
      .quo    (quo),
      .last_c (last_c)
   );

   // Divide by zero leaves rem = |a|, so the remainder fix-up restores hi = a
   always_comb begin
      prod_fix = neg_q ? (2*WIDTH)'(-{rem, quo}) : {rem, quo};
      if (div_q) begin
         res_lo = b_zero_q ? '1 : (neg_q ? WIDTH'(-quo) : quo);
         res_hi = neg_r ? WIDTH'(-rem) : rem;
      end else begin
         res_lo = prod_fix[WIDTH-1:0];
         res_hi = prod_fix[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge clk_cpu or posedge reset) begin
      if (reset) begin
         hi   <= '0;
         lo   <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_nxt != ST_IDLE);
         done <= fin_c;
         if (fin_c) begin
            hi <= res_hi;
            lo <= res_lo;
         end else if (state == ST_IDLE) begin
            if (hi_wr) hi <= wr_data;
            if (lo_wr) lo <= wr_data;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table through a result scoreboard plus control-path sequences.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   localparam int unsigned W   = 32;
   localparam int          LAT = 33;

   logic         clk_cpu = 1'b0;
   logic         reset   = 1'b1;
   logic         start   = 1'b0;
   logic [1:0]   op      = 2'd0;
   logic [W-1:0] a       = '0;
   logic [W-1:0] b       = '0;
   logic         cancel  = 1'b0;
   logic         hi_wr   = 1'b0;
   logic         lo_wr   = 1'b0;
   logic [W-1:0] wr_data = '0;
   logic [W-1:0] hi, lo;
   logic         busy, done;

   int n_vec  = 0;
   int n_fail = 0;
   logic [2*W-1:0] exp_q[$];

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_hi;
      logic [W-1:0] exp_lo;
   } vec_t;

   vec_t vecs[11];

   muldiv_unit #(.WIDTH(W)) dut (
      .clk_cpu (clk_cpu),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .cancel  (cancel),
      .hi_wr   (hi_wr),
      .lo_wr   (lo_wr),
      .wr_data (wr_data),
      .hi      (hi),
      .lo      (lo),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk_cpu = ~clk_cpu;

   task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest pending result
   always @(negedge clk_cpu) begin
      if (done) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
         end else begin
            logic [2*W-1:0] e;
            e = exp_q.pop_front();
            if ({hi, lo} !== e) begin
               n_fail++;
               $display("FAIL result: got %h expected %h", {hi, lo}, e);
            end
         end
      end
   end

   task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit push, input logic [2*W-1:0] e);
      @(posedge clk_cpu); #1;
      op = o; a = x; b = y; start = 1'b1;
      if (push) exp_q.push_back(e);
      @(posedge clk_cpu); #1;
      start = 1'b0;
   endtask

   // elapsed = edges since the accepting edge already consumed by the caller
   task automatic wait_done(input string name, input int elapsed);
      int n;
      n = elapsed;
      while (n < 200) begin
         @(posedge clk_cpu); #1;
         n++;
         if (done) break;
      end
      chk({name, "_latency"}, (2*W)'(n), (2*W)'(LAT));
      chk({name, "_busy_at_done"}, (2*W)'(busy), '0);
   endtask

   initial begin
      vecs[0]  = '{MD_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[1]  = '{MD_OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[2]  = '{MD_OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
      vecs[3]  = '{MD_OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[4]  = '{MD_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5]  = '{MD_OP_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
      vecs[6]  = '{MD_OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
      vecs[7]  = '{MD_OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[8]  = '{MD_OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[9]  = '{MD_OP_MULTU, 32'h12345678, 32'h00000009, 32'h00000000, 32'hA3D70A38};
      vecs[10] = '{MD_OP_MULT,  32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB};

      #1;
      chk("reset_hi",   (2*W)'(hi),   '0);
      chk("reset_lo",   (2*W)'(lo),   '0);
      chk("reset_busy", (2*W)'(busy), '0);
      chk("reset_done", (2*W)'(done), '0);
      repeat (2) @(posedge clk_cpu);
      #1 reset = 1'b0;

      foreach (vecs[i]) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, {vecs[i].exp_hi, vecs[i].exp_lo});
         chk($sformatf("vec%0d_busy", i), (2*W)'(busy), (2*W)'(1));
         wait_done($sformatf("vec%0d", i), 0);
      end

      // MTLO then cancelled MULTU: lo keeps the written value, no done
      @(posedge clk_cpu); #1;
      lo_wr = 1'b1; wr_data = 32'hAA;
      @(posedge clk_cpu); #1;
      lo_wr = 1'b0;
      chk("mtlo", (2*W)'(lo), (2*W)'(32'hAA));
      issue(MD_OP_MULTU, 32'd2, 32'd3, 1'b0, '0);
      repeat (9) @(posedge clk_cpu);
      #1 cancel = 1'b1;
      @(posedge clk_cpu); #1;
      cancel = 1'b0;
      chk("cancel_busy", (2*W)'(busy), '0);
      chk("cancel_lo",   (2*W)'(lo),   (2*W)'(32'hAA));
      repeat (40) @(posedge clk_cpu);
      #1 chk("cancel_lo_later", (2*W)'(lo), (2*W)'(32'hAA));

      // cancel wins over start in IDLE
      start = 1'b1; cancel = 1'b1; op = MD_OP_MULTU; a = 32'd9; b = 32'd9;
      @(posedge clk_cpu); #1;
      start = 1'b0; cancel = 1'b0;
      chk("cancel_idle_busy", (2*W)'(busy), '0);

      // start and MTLO while busy are ignored
      issue(MD_OP_MULTU, 32'd6, 32'd7, 1'b1, {32'd0, 32'd42});
      repeat (4) @(posedge clk_cpu);
      #1;
      start = 1'b1; op = MD_OP_MULTU; a = 32'd1; b = 32'd1;
      lo_wr = 1'b1; wr_data = 32'hDEAD;
      @(posedge clk_cpu); #1;
      start = 1'b0; lo_wr = 1'b0;
      chk("busy_wr_ignored", (2*W)'(lo), (2*W)'(32'hAA));
      chk("busy_still",      (2*W)'(busy), (2*W)'(1));
      wait_done("busy_start", 5);
      repeat (40) @(posedge clk_cpu);

      // MTLO on the accepting edge takes effect, then FIN overwrites it
      #1;
      op = MD_OP_DIVU; a = 32'd1000; b = 32'd10; start = 1'b1;
      lo_wr = 1'b1; wr_data = 32'h55;
      exp_q.push_back({32'd0, 32'd100});
      @(posedge clk_cpu); #1;
      start = 1'b0; lo_wr = 1'b0;
      chk("wr_with_start", (2*W)'(lo), (2*W)'(32'h55));
      wait_done("wr_with_start", 0);

      // asynchronous reset mid-divide
      issue(MD_OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, '0);
      repeat (4) @(posedge clk_cpu);
      @(negedge clk_cpu);
      reset = 1'b1;
      #1;
      chk("midreset_hi",   (2*W)'(hi),   '0);
      chk("midreset_lo",   (2*W)'(lo),   '0);
      chk("midreset_busy", (2*W)'(busy), '0);
      chk("midreset_done", (2*W)'(done), '0);
      @(posedge clk_cpu); #1;
      reset = 1'b0;
      issue(MD_OP_MULTU, 32'd4, 32'd5, 1'b1, {32'd0, 32'd20});
      wait_done("after_reset", 0);

      repeat (3) @(posedge clk_cpu);
      chk("scoreboard_empty", (2*W)'(exp_q.size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width; HI and LO are each WIDTH bits; legal WIDTH is an even number >= 8.
REQ-002 SHALL have port clk_cpu  input  1  CPU clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: MULT, MULTU, DIV or DIVU.
REQ-006 SHALL have port a  input  WIDTH  multiplicand or dividend, sampled on the accepting edge.
REQ-007 SHALL have port b  input  WIDTH  multiplier or divisor, sampled on the accepting edge.
REQ-008 SHALL have port cancel  input  1  abort of an in-flight operation, for example on a pipeline exception.
REQ-009 SHALL have port hi_wr  input  1  MTHI write strobe.
REQ-010 SHALL have port lo_wr  input  1  MTLO write strobe.
REQ-011 SHALL have port wr_data  input  WIDTH  data for hi_wr and lo_wr.
REQ-012 SHALL have port hi  output  WIDTH  HI register: product upper half or remainder.
REQ-013 SHALL have port lo  output  WIDTH  LO register: product lower half or quotient.
REQ-014 SHALL have port busy  output  1  high while an operation is in flight; the CPU stalls MFHI, MFLO and a new multiply/divide while busy is high.
REQ-015 SHALL have port done  output  1  one-cycle pulse when a result has been written to HI and LO.

Function
REQ-016 SHALL implement the states IDLE, RUN and FIN; busy SHALL equal (state != IDLE).
REQ-017 IDLE with start=1 and cancel=0 SHALL, on that edge (E0), latch op and the operand magnitudes, clear the iteration counter and enter RUN.
REQ-018 RUN SHALL perform one radix-2 step per cycle (multiply: shift-add; divide: restoring shift-subtract) and SHALL enter FIN on the edge where the counter reaches WIDTH-1.
REQ-019 FIN SHALL apply the sign fix-up, write HI and LO, and return to IDLE; done SHALL be 1 for exactly the following cycle, when busy is 0 and the new HI/LO are visible.
REQ-020 Latency: done SHALL be high WIDTH+1 cycles after E0 (33 cycles at WIDTH=32), and busy SHALL be high for WIDTH+1 cycles.
REQ-021 MULT/MULTU SHALL produce the full 2*WIDTH-bit product, {hi,lo}; for MULT the product sign is a[MSB] XOR b[MSB].
REQ-022 DIV/DIVU SHALL set lo to the quotient and hi to the remainder; signed division SHALL truncate toward zero, with the remainder taking the sign of a.
REQ-023 Division by zero (any divide op, b=0) SHALL produce lo = all ones and hi = a, still with the full latency.
REQ-024 Signed DIV of MIN by -1 SHALL produce lo=MIN and hi=0, with no other effect.
REQ-025 start while busy SHALL be ignored: no queueing and no effect on the current operation.
REQ-026 cancel in RUN or FIN SHALL return to IDLE on the next edge, leaving hi/lo unchanged and producing no done pulse; cancel in IDLE is a no-op and SHALL win over a simultaneous start.
REQ-027 hi_wr/lo_wr SHALL write wr_data to hi/lo on the edge only when in IDLE, and SHALL be ignored while busy.
REQ-028 If hi_wr/lo_wr and an accepted start occur on the same edge, the write SHALL take effect, and a later FIN SHALL overwrite it.

Reset
REQ-029 Asserting reset SHALL immediately force IDLE, hi=0, lo=0, busy=0 and done=0, and clear the counter and operand registers, including when it is asserted mid-operation.
REQ-030 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Structure
REQ-031 The op encodings (MD_OP_MULT=0, MD_OP_MULTU=1, MD_OP_DIV=2, MD_OP_DIVU=3) and the state encodings SHALL live in the shared defines file.
REQ-032 The iterative datapath SHALL be one sub-module, muldiv_iter, containing the shift registers, adder/subtractor and counter; muldiv_unit SHALL contain the FSM, sign fix-up and HI/LO registers.

Verification (WIDTH=32)
REQ-033 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 cycles after start.
REQ-034 MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIVU 100/7 -> lo=14, hi=2.
REQ-035 DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 DIVU a=0x12345678 b=0 -> lo=0xFFFFFFFF, hi=0x12345678, after the full latency.
REQ-037 MTLO 0xAA, then MULTU 2*3 with cancel at cycle 10 -> busy=0 on the next cycle, no done, lo stays 0xAA; start pulsed while busy -> no extra done.
REQ-038 reset at cycle 5 of a DIV -> hi=lo=0 and busy=0 immediately; a new MULTU 4*5 -> lo=20 after 33 cycles.
